// File: rtl/cpu_bus_arbiter.sv
// Two-port memory bus arbiter: port 0 (data) and port 1 (instruction fetch)
// share one bus. Round-robin on ties, registered bus attributes, and a
// per-transaction timeout that completes the access with a fault pulse.
//
// Ports:
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_pN_request/rw/address/wdata   requester N transaction inputs
//   o_pN_rdata/ready/fault          requester N completion outputs
//   o_bus_request/rw/address/wdata  bus master outputs
//   i_bus_rdata, i_bus_ready        bus return data and completion strobe
//   o_grant                         current or last granted port index
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_p0_request,
  input  logic        i_p0_rw,
  input  logic [31:0] i_p0_address,
  input  logic [31:0] i_p0_wdata,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ready,
  output logic        o_p0_fault,
  input  logic        i_p1_request,
  input  logic        i_p1_rw,
  input  logic [31:0] i_p1_address,
  input  logic [31:0] i_p1_wdata,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ready,
  output logic        o_p1_fault,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RELEASE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_grant;
  logic [7:0]  r_count;
  logic        r_bus_rw;
  logic [31:0] r_bus_address;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;
  logic        r_p0_ready;
  logic        r_p1_ready;
  logic        r_p0_fault;
  logic        r_p1_fault;

  logic        w_grant_valid;
  logic        w_grant_sel;
  logic        w_done;
  logic        w_fault;
  logic        w_g_request;
  logic [7:0]  w_count_inc;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant_valid = 1'b0;
    w_grant_sel   = r_grant;
    w_done        = 1'b0;
    w_fault       = 1'b0;
    w_count_inc   = r_count + 8'd1;
    w_g_request   = r_grant ? i_p1_request : i_p0_request;

    case (r_state)
      S_IDLE: begin
        if (i_p0_request && i_p1_request) begin
          w_grant_valid = 1'b1;
          w_grant_sel   = ~r_grant;
        end else if (i_p0_request) begin
          w_grant_valid = 1'b1;
          w_grant_sel   = 1'b0;
        end else if (i_p1_request) begin
          w_grant_valid = 1'b1;
          w_grant_sel   = 1'b1;
        end
        if (w_grant_valid) begin
          w_state_next = S_BUS;
        end
      end
      S_BUS: begin
        // i_bus_ready takes priority over a coincident timeout
        if (i_bus_ready) begin
          w_done       = 1'b1;
          w_state_next = S_RELEASE;
        end else if (w_count_inc == 8'(TIMEOUT)) begin
          w_done       = 1'b1;
          w_fault      = 1'b1;
          w_state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!w_g_request) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant       <= 1'b1;
      r_count       <= '0;
      r_bus_rw      <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
      r_p0_rdata    <= '0;
      r_p1_rdata    <= '0;
      r_p0_ready    <= 1'b0;
      r_p1_ready    <= 1'b0;
      r_p0_fault    <= 1'b0;
      r_p1_fault    <= 1'b0;
    end else begin
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      r_p0_fault <= 1'b0;
      r_p1_fault <= 1'b0;

      if (w_grant_valid) begin
        r_grant       <= w_grant_sel;
        r_count       <= '0;
        r_bus_rw      <= w_grant_sel ? i_p1_rw      : i_p0_rw;
        r_bus_address <= w_grant_sel ? i_p1_address : i_p0_address;
        r_bus_wdata   <= w_grant_sel ? i_p1_wdata   : i_p0_wdata;
      end

      if (r_state == S_BUS && !i_bus_ready) begin
        r_count <= w_count_inc;
      end

      if (w_done) begin
        if (r_grant) begin
          r_p1_ready <= 1'b1;
          r_p1_fault <= w_fault;
          if (!w_fault && !r_bus_rw) begin
            r_p1_rdata <= i_bus_rdata;
          end
        end else begin
          r_p0_ready <= 1'b1;
          r_p0_fault <= w_fault;
          if (!w_fault && !r_bus_rw) begin
            r_p0_rdata <= i_bus_rdata;
          end
        end
      end
    end
  end

  assign o_bus_request = (r_state == S_BUS);
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_grant       = r_grant;
  assign o_p0_rdata    = r_p0_rdata;
  assign o_p1_rdata    = r_p1_rdata;
  assign o_p0_ready    = r_p0_ready;
  assign o_p1_ready    = r_p1_ready;
  assign o_p0_fault    = r_p0_fault;
  assign o_p1_fault    = r_p1_fault;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_p0_request, i_p0_rw, i_p1_request, i_p1_rw;
  logic [31:0] i_p0_address, i_p0_wdata, i_p1_address, i_p1_wdata;
  logic [31:0] o_p0_rdata, o_p1_rdata;
  logic        o_p0_ready, o_p0_fault, o_p1_ready, o_p1_fault;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ready;
  logic        o_grant;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_rdata [2];

  always #5 i_clock = ~i_clock;

  cpu_bus_arbiter #(.TIMEOUT(4)) u_dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_p0_request (i_p0_request),
    .i_p0_rw      (i_p0_rw),
    .i_p0_address (i_p0_address),
    .i_p0_wdata   (i_p0_wdata),
    .o_p0_rdata   (o_p0_rdata),
    .o_p0_ready   (o_p0_ready),
    .o_p0_fault   (o_p0_fault),
    .i_p1_request (i_p1_request),
    .i_p1_rw      (i_p1_rw),
    .i_p1_address (i_p1_address),
    .i_p1_wdata   (i_p1_wdata),
    .o_p1_rdata   (o_p1_rdata),
    .o_p1_ready   (o_p1_ready),
    .o_p1_fault   (o_p1_fault),
    .o_bus_request(o_bus_request),
    .o_bus_rw     (o_bus_rw),
    .o_bus_address(o_bus_address),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_rdata  (i_bus_rdata),
    .i_bus_ready  (i_bus_ready),
    .o_grant      (o_grant)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_req(input logic p, input logic v);
    if (p) i_p1_request = v;
    else   i_p0_request = v;
  endtask

  // Both requests assumed high in IDLE; serves one read and rearms the port.
  task automatic serve(input logic g, input logic [31:0] val);
    tick();
    check("rr_grant", 32'(o_grant), 32'(g));
    check("rr_busreq", 32'(o_bus_request), 32'd1);
    i_bus_ready = 1'b1;
    i_bus_rdata = val;
    tick();
    exp_rdata[g] = val;
    check("rr_ready_g", 32'(g ? o_p1_ready : o_p0_ready), 32'd1);
    check("rr_ready_other", 32'(g ? o_p0_ready : o_p1_ready), 32'd0);
    check("rr_rdata_g", g ? o_p1_rdata : o_p0_rdata, exp_rdata[g]);
    check("rr_rdata_other", g ? o_p0_rdata : o_p1_rdata, exp_rdata[~g]);
    i_bus_ready = 1'b0;
    set_req(g, 1'b0);
    tick();
    check("rr_idle_busreq", 32'(o_bus_request), 32'd0);
    set_req(g, 1'b1);
  endtask

  initial begin
    i_reset = 1'b1;
    i_p0_request = 0; i_p0_rw = 0; i_p0_address = '0; i_p0_wdata = '0;
    i_p1_request = 0; i_p1_rw = 0; i_p1_address = '0; i_p1_wdata = '0;
    i_bus_rdata = '0; i_bus_ready = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    tick(); tick();
    check("rst_busreq", 32'(o_bus_request), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd1);
    check("rst_ready", {30'd0, o_p1_ready, o_p0_ready}, 32'd0);
    check("rst_fault", {30'd0, o_p1_fault, o_p0_fault}, 32'd0);
    check("rst_addr", o_bus_address, 32'd0);
    check("rst_rdata0", o_p0_rdata, 32'd0);
    i_reset = 1'b0;
    tick();

    // port 0 read, ready on third bus cycle
    i_p0_request = 1; i_p0_rw = 0; i_p0_address = 32'h100;
    tick();
    check("rd_busreq", 32'(o_bus_request), 32'd1);
    check("rd_addr", o_bus_address, 32'h100);
    check("rd_rw", 32'(o_bus_rw), 32'd0);
    check("rd_grant", 32'(o_grant), 32'd0);
    i_p0_address = 32'h999;
    tick();
    check("rd_addr_hold", o_bus_address, 32'h100);
    check("rd_noready", 32'(o_p0_ready), 32'd0);
    tick();
    i_bus_ready = 1; i_bus_rdata = 32'hDEADBEEF;
    tick();
    exp_rdata[0] = 32'hDEADBEEF;
    check("rd_ready", 32'(o_p0_ready), 32'd1);
    check("rd_fault", 32'(o_p0_fault), 32'd0);
    check("rd_rdata", o_p0_rdata, 32'hDEADBEEF);
    check("rd_p1ready", 32'(o_p1_ready), 32'd0);
    check("rd_busreq_drop", 32'(o_bus_request), 32'd0);
    i_bus_ready = 0; i_bus_rdata = 32'h0BAD0BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_busreq", 32'(o_bus_request), 32'd0);
      check("hold_ready", 32'(o_p0_ready), 32'd0);
    end
    i_p0_request = 0;
    tick();
    tick();
    check("hold_idle", 32'(o_bus_request), 32'd0);

    // round robin after reset: 0,1,0,1
    i_reset = 1; tick(); i_reset = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    i_p0_request = 1; i_p0_rw = 0; i_p0_address = 32'h10;
    i_p1_request = 1; i_p1_rw = 0; i_p1_address = 32'h20;
    serve(1'b0, 32'hA0000000);
    serve(1'b1, 32'hA0000001);
    serve(1'b0, 32'hA0000002);
    serve(1'b1, 32'hA0000003);
    i_p0_request = 0; i_p1_request = 0;
    tick();

    // port 1 write
    i_p1_request = 1; i_p1_rw = 1; i_p1_address = 32'h2000; i_p1_wdata = 32'h12345678;
    tick();
    check("wr_rw", 32'(o_bus_rw), 32'd1);
    check("wr_addr", o_bus_address, 32'h2000);
    check("wr_wdata", o_bus_wdata, 32'h12345678);
    check("wr_grant", 32'(o_grant), 32'd1);
    i_bus_ready = 1; i_bus_rdata = 32'hCAFEF00D;
    tick();
    check("wr_ready", 32'(o_p1_ready), 32'd1);
    check("wr_rdata_hold", o_p1_rdata, exp_rdata[1]);
    check("wr_p0ready", 32'(o_p0_ready), 32'd0);
    i_bus_ready = 0; i_p1_request = 0;
    tick();

    // timeout after 4 bus cycles
    i_p0_request = 1; i_p0_rw = 0; i_p0_address = 32'h40; i_bus_rdata = 32'h77777777;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_busreq", 32'(o_bus_request), 32'd1);
      check("to_noready", 32'(o_p0_ready), 32'd0);
    end
    tick();
    check("to_ready", 32'(o_p0_ready), 32'd1);
    check("to_fault", 32'(o_p0_fault), 32'd1);
    check("to_rdata", o_p0_rdata, exp_rdata[0]);
    check("to_busreq_drop", 32'(o_bus_request), 32'd0);
    check("to_p1", {30'd0, o_p1_fault, o_p1_ready}, 32'd0);
    i_p0_request = 0;
    tick();
    tick();
    check("to_pulse_once", 32'(o_p0_ready), 32'd0);

    // ready coincident with timeout: ready wins
    i_p0_request = 1;
    tick();
    tick(); tick(); tick();
    i_bus_ready = 1; i_bus_rdata = 32'h000055AA;
    tick();
    exp_rdata[0] = 32'h000055AA;
    check("tie_ready", 32'(o_p0_ready), 32'd1);
    check("tie_fault", 32'(o_p0_fault), 32'd0);
    check("tie_rdata", o_p0_rdata, exp_rdata[0]);
    i_bus_ready = 0; i_p0_request = 0;
    tick();

    // request dropped during bus still completes
    i_p0_request = 1;
    tick();
    i_p0_request = 0;
    tick();
    check("drop_busreq", 32'(o_bus_request), 32'd1);
    i_bus_ready = 1; i_bus_rdata = 32'h31415926;
    tick();
    exp_rdata[0] = 32'h31415926;
    check("drop_ready", 32'(o_p0_ready), 32'd1);
    check("drop_rdata", o_p0_rdata, exp_rdata[0]);
    i_bus_ready = 0;
    tick();

    // reset during bus aborts with no ready
    i_p1_request = 1; i_p1_rw = 0;
    tick();
    check("rb_busreq", 32'(o_bus_request), 32'd1);
    i_reset = 1; i_bus_ready = 1;
    tick();
    check("rb_busreq_drop", 32'(o_bus_request), 32'd0);
    check("rb_ready", {30'd0, o_p1_ready, o_p0_ready}, 32'd0);
    check("rb_grant", 32'(o_grant), 32'd1);
    check("rb_rdata1", o_p1_rdata, 32'd0);
    i_reset = 0; i_bus_ready = 0; i_p1_request = 0;
    tick();
    check("rb_after", 32'(o_p1_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Purpose: shares one memory bus between port 0 (data accesses from execute/memory stage) and port 1 (instruction fetch).

Interface
REQ-001 Parameter TIMEOUT, default 255: number of bus cycles to wait for i_bus_ready before aborting the transaction.
REQ-002 i_clock  input  1  clock; all state updates on the rising edge.
REQ-003 i_reset  input  1  reset; synchronous, active-high.
REQ-004 i_pN_request  input  1  (N=0,1) port N requests a transaction.
REQ-005 i_pN_rw  input  1  (N=0,1) 1=write, 0=read.
REQ-006 i_pN_address  input  32  (N=0,1) byte address.
REQ-007 i_pN_wdata  input  32  (N=0,1) write data.
REQ-008 o_pN_rdata  output  32  (N=0,1) read data returned to port N.
REQ-009 o_pN_ready  output  1  (N=0,1) one-cycle completion pulse to port N.
REQ-010 o_pN_fault  output  1  (N=0,1) one-cycle pulse, coincident with o_pN_ready, on timeout.
REQ-011 o_bus_request, o_bus_rw  output  1 each  bus request and direction.
REQ-012 o_bus_address, o_bus_wdata  output  32 each  bus address and data.
REQ-013 i_bus_rdata  input  32  bus read data, valid while i_bus_ready=1.
REQ-014 i_bus_ready  input  1  bus completion strobe.
REQ-015 o_grant  output  1  index of the current or last granted port.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUS and RELEASE.
REQ-017 In IDLE with exactly one request high, the arbiter SHALL grant that port.
REQ-018 In IDLE with both requests high, the arbiter SHALL grant the port not granted last (round-robin).
REQ-019 On grant, the arbiter SHALL move to BUS and register o_grant, rw, address and wdata from the granted port.
REQ-020 o_bus_request SHALL be 1 exactly while the state is BUS, starting the cycle after grant.
REQ-021 Grant latency SHALL be 1 cycle: request sampled at edge T, o_bus_request high after edge T.
REQ-022 Bus attributes SHALL stay constant while in BUS, even if requester inputs change.
REQ-023 In BUS with i_bus_ready=1, the arbiter SHALL set o_pG_ready=1 for exactly one cycle (G = granted port), load o_pG_rdata with i_bus_rdata on reads, drop o_bus_request and enter RELEASE.
REQ-024 On writes, o_pG_rdata SHALL hold its previous value.
REQ-025 A 8-bit cycle counter SHALL clear on entry to BUS and increment each BUS cycle without i_bus_ready.
REQ-026 When the counter reaches TIMEOUT, the arbiter SHALL pulse o_pG_ready and o_pG_fault together, leave o_pG_rdata unchanged and enter RELEASE.
REQ-027 If i_bus_ready and timeout occur in the same cycle, i_bus_ready SHALL win and no fault is raised.
REQ-028 In RELEASE, the arbiter SHALL stay until i_pG_request=0, then return to IDLE; the other port's request is arbitrated no earlier than that IDLE cycle.
REQ-029 If a requester drops its request while in BUS, the transaction SHALL still complete and the ready pulse SHALL still be issued.
REQ-030 A non-granted port's o_ready and o_fault SHALL remain 0.
REQ-031 o_pN_rdata SHALL change only on a successful read completion for port N.

Reset
REQ-032 Reset SHALL force state IDLE, counter 0, o_grant 1 (so port 0 wins the first tie), all o_ready/o_fault/o_bus_request 0, and all data/address outputs 0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ready pulse.

Verification
REQ-034 Port 0 read of 0x100, bus returns 0xDEADBEEF after 3 cycles -> o_p0_ready pulses once, o_p0_rdata=0xDEADBEEF, o_p1_ready stays 0.
REQ-035 Both ports request after reset -> port 0 served first, port 1 second; repeat with requests held -> strict alternation 0,1,0,1.
REQ-036 Port 1 write of addr 0x2000, data 0x12345678 -> bus sees rw=1 with those values; o_p1_rdata unchanged.
REQ-037 TIMEOUT=4, bus never ready -> o_p0_ready and o_p0_fault pulse together after 4 BUS cycles, then RELEASE.
REQ-038 Requester holds request 5 cycles after ready -> no second bus transaction until the request drops; reset during BUS -> o_bus_request 0 the next cycle and no ready pulse.
